// File: rtl/lpc_host.sv
// LPC host controller: turns one host request into an LPC I/O or memory
// read/write cycle, handles SYNC wait states and timeout abort, and reports
// completion with a one-cycle resp_valid pulse. All outputs are registered.
module lpc_host #(
  parameter int SYNC_TIMEOUT = 8
) (
  input  logic        lpc_clock,
  input  logic        lpc_reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_mem,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        resp_valid,
  output logic [7:0]  resp_rdata,
  output logic        resp_error,
  output logic        lpc_frame,
  output logic [3:0]  lpc_ad_out,
  output logic        lpc_ad_oe,
  input  logic [3:0]  lpc_ad_in
);

  localparam logic [3:0] IDLE    = 4'd0;
  localparam logic [3:0] START   = 4'd1;
  localparam logic [3:0] CYCTYPE = 4'd2;
  localparam logic [3:0] ADDR    = 4'd3;
  localparam logic [3:0] WDATA   = 4'd4;
  localparam logic [3:0] TAR1    = 4'd5;
  localparam logic [3:0] TAR2    = 4'd6;
  localparam logic [3:0] SYNC    = 4'd7;
  localparam logic [3:0] RDATA   = 4'd8;
  localparam logic [3:0] PTAR    = 4'd9;
  localparam logic [3:0] ABORT   = 4'd10;
  localparam logic [3:0] RESP    = 4'd11;

  localparam logic [7:0] TIMEOUT = 8'(SYNC_TIMEOUT);

  logic [3:0]  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  wait_q, wait_d;
  logic        err_q, err_d;
  logic        ready_q, ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [7:0]  resp_rdata_q, resp_rdata_d;
  logic        resp_error_q, resp_error_d;
  logic        frame_q, frame_d;
  logic [3:0]  ad_q, ad_d;
  logic        oe_q, oe_d;

  logic        mem_q, write_q;
  logic [31:0] addr_q;
  logic [7:0]  wdata_q;
  logic [7:0]  rbuf_q, rbuf_d;
  logic        capture;
  logic [2:0]  nib;

  // Next-state logic: sequencing through the LPC frame and SYNC handling
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wait_d       = wait_q;
    err_d        = err_q;
    rbuf_d       = rbuf_q;
    capture      = 1'b0;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_error_d = resp_error_q;
    case (state_q)
      IDLE: if (req_valid) begin
        state_d = START;
        capture = 1'b1;
        err_d   = 1'b0;
        rbuf_d  = 8'h00;
      end
      START:   begin state_d = CYCTYPE; cnt_d = 3'd0; end
      CYCTYPE: begin state_d = ADDR;    cnt_d = 3'd0; end
      ADDR: begin
        if (cnt_q == (mem_q ? 3'd7 : 3'd3)) begin
          cnt_d   = 3'd0;
          state_d = write_q ? WDATA : TAR1;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      WDATA: begin
        if (cnt_q == 3'd1) begin
          cnt_d   = 3'd0;
          state_d = TAR1;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      TAR1: state_d = TAR2;
      TAR2: begin state_d = SYNC; wait_d = 8'd0; end
      SYNC: begin
        case (lpc_ad_in)
          4'b0000: begin state_d = write_q ? PTAR : RDATA; cnt_d = 3'd0; end
          4'b1010: begin state_d = write_q ? PTAR : RDATA; cnt_d = 3'd0; err_d = 1'b1; end
          4'b0110: wait_d = wait_q;
          default: begin
            // Short wait and every unrecognised code both count toward timeout
            wait_d = wait_q + 8'd1;
            if (wait_q + 8'd1 >= TIMEOUT) begin
              state_d = ABORT;
              cnt_d   = 3'd0;
            end
          end
        endcase
      end
      RDATA: begin
        if (cnt_q == 3'd0) begin
          rbuf_d[3:0] = lpc_ad_in;
          cnt_d       = 3'd1;
        end else begin
          rbuf_d[7:4] = lpc_ad_in;
          cnt_d       = 3'd0;
          state_d     = PTAR;
        end
      end
      PTAR: begin
        if (cnt_q == 3'd1) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = rbuf_q;
          resp_error_d = err_q;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ABORT: begin
        if (cnt_q == 3'd3) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = 8'h00;
          resp_error_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus output decode from the upcoming state so pins are registered with it
  always_comb begin
    frame_d = 1'b1;
    oe_d    = 1'b0;
    ad_d    = 4'hF;
    nib     = (mem_q ? 3'd7 : 3'd3) - cnt_d;
    ready_d = (state_d == IDLE);
    case (state_d)
      START:   begin frame_d = 1'b0; oe_d = 1'b1; ad_d = 4'h0; end
      CYCTYPE: begin oe_d = 1'b1; ad_d = {1'b0, mem_q, write_q, 1'b0}; end
      ADDR:    begin oe_d = 1'b1; ad_d = addr_q[{nib, 2'b00} +: 4]; end
      WDATA:   begin oe_d = 1'b1; ad_d = (cnt_d == 3'd0) ? wdata_q[3:0] : wdata_q[7:4]; end
      TAR1:    begin oe_d = 1'b1; ad_d = 4'hF; end
      ABORT:   begin frame_d = 1'b0; oe_d = 1'b1; ad_d = 4'hF; end
      default: begin frame_d = 1'b1; oe_d = 1'b0; ad_d = 4'hF; end
    endcase
  end

  // Control state and registered outputs, cleared by the asynchronous reset
  always_ff @(posedge lpc_clock or negedge lpc_reset) begin
    if (!lpc_reset) begin
      state_q      <= IDLE;
      cnt_q        <= 3'd0;
      wait_q       <= 8'd0;
      err_q        <= 1'b0;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 8'h00;
      resp_error_q <= 1'b0;
      frame_q      <= 1'b1;
      ad_q         <= 4'hF;
      oe_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wait_q       <= wait_d;
      err_q        <= err_d;
      ready_q      <= ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_error_q <= resp_error_d;
      frame_q      <= frame_d;
      ad_q         <= ad_d;
      oe_q         <= oe_d;
    end
  end

  // Request fields latched at acceptance and read data assembly
  always_ff @(posedge lpc_clock) begin
    if (capture) begin
      mem_q   <= req_mem;
      write_q <= req_write;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
    rbuf_q <= rbuf_d;
  end

  assign req_ready  = ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_error = resp_error_q;
  assign lpc_frame  = frame_q;
  assign lpc_ad_out = ad_q;
  assign lpc_ad_oe  = oe_q;

endmodule

// File: tb/tb_lpc_host.sv
// Testbench for lpc_host: directed vector table, reset corner cases and
// randomized transactions checked against a transaction-level LPC model.
module tb_lpc_host;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_mem = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic        resp_valid;
  logic [7:0]  resp_rdata;
  logic        resp_error;
  logic        lpc_frame;
  logic [3:0]  lpc_ad_out;
  logic        lpc_ad_oe;
  logic [3:0]  lpc_ad_in = 4'hF;

  int passed = 0;
  int total  = 0;

  lpc_host #(.SYNC_TIMEOUT(TMO)) dut (
    .lpc_clock(clk), .lpc_reset(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_mem(req_mem), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .lpc_frame(lpc_frame), .lpc_ad_out(lpc_ad_out), .lpc_ad_oe(lpc_ad_oe),
    .lpc_ad_in(lpc_ad_in)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            mem;
    logic            wr;
    logic [31:0]     addr;
    logic [7:0]      wdata;
    logic [7:0]      rdata;
    logic [23:0][3:0] codes;
    int              ncodes;
    int              exp_resp;
    logic [7:0]      exp_rd;
    logic            exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic vec_t mkv(input logic mem, input logic wr, input logic [31:0] addr,
                               input logic [7:0] wdata, input logic [7:0] rdata,
                               input int exp_resp, input logic [7:0] exp_rd, input logic exp_err);
    vec_t v;
    v.mem = mem; v.wr = wr; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.codes = '0; v.ncodes = 0;
    v.exp_resp = exp_resp; v.exp_rd = exp_rd; v.exp_err = exp_err;
    return v;
  endfunction

  // One full transaction; entered and left at 1 time unit after a rising edge.
  // use_tab selects the hand-written table expectations for latency/result.
  task automatic run_txn(input vec_t v, input bit use_tab);
    logic [3:0] drv[$];
    logic [3:0] code;
    int s, nsync, waits, resp, first_rv, guard, last;
    bit abort, serr, done, bus_bad, ready_bad, oe_bad;
    logic [7:0] m_rd, got_rd, hold_rd;
    logic m_err, got_err;

    // Transaction-level model: pin sequence the host must drive
    drv.push_back(4'h0);
    drv.push_back({1'b0, v.mem, v.wr, 1'b0});
    for (int i = (v.mem ? 7 : 3); i >= 0; i--) drv.push_back(v.addr[i*4 +: 4]);
    if (v.wr) begin drv.push_back(v.wdata[3:0]); drv.push_back(v.wdata[7:4]); end
    drv.push_back(4'hF);
    s = drv.size() + 1;
    // SYNC rules applied to the peripheral's code stream
    waits = 0; nsync = 0; abort = 0; serr = 0; done = 0;
    while (!done && nsync < 300) begin
      code = (nsync < v.ncodes) ? v.codes[nsync] : 4'hF;
      nsync++;
      if (code == 4'h0) done = 1;
      else if (code == 4'hA) begin done = 1; serr = 1; end
      else if (code != 4'h6) begin
        waits++;
        if (waits == TMO) begin abort = 1; done = 1; end
      end
    end
    resp  = abort ? s + nsync + 4 : s + nsync + (v.wr ? 0 : 2) + 2;
    m_rd  = (abort || v.wr) ? 8'h00 : v.rdata;
    m_err = abort | serr;
    if (use_tab) begin resp = v.exp_resp; m_rd = v.exp_rd; m_err = v.exp_err; end

    req_valid = 1'b1; req_mem = v.mem; req_write = v.wr;
    req_addr = v.addr; req_wdata = v.wdata;
    guard = 0;
    while (!req_ready && guard < 60) begin @(posedge clk); #1; guard++; end
    if (!req_ready) begin
      chk("accept_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    // Fields change right after acceptance and must be ignored
    req_valid = 1'b0; req_mem = ~v.mem; req_write = ~v.wr;
    req_addr = $urandom; req_wdata = 8'($urandom);

    bus_bad = 0; ready_bad = 0; oe_bad = 0; first_rv = -1;
    got_rd = 8'hxx; got_err = 1'bx; hold_rd = 8'hxx;
    last = resp + 1;
    for (int k = 0; k <= last; k++) begin
      if (k < drv.size()) begin
        if (lpc_ad_oe !== 1'b1 || lpc_ad_out !== drv[k] || lpc_frame !== (k != 0)) bus_bad = 1;
      end else if (abort && k >= s + nsync && k < s + nsync + 4) begin
        if (lpc_frame !== 1'b0 || lpc_ad_oe !== 1'b1 || lpc_ad_out !== 4'hF) bus_bad = 1;
      end else if (k < resp) begin
        if (lpc_ad_oe !== 1'b0) oe_bad = 1;
        if (lpc_frame !== 1'b1) bus_bad = 1;
      end
      if (k < resp && req_ready !== 1'b0) ready_bad = 1;
      if (resp_valid === 1'b1 && first_rv < 0) begin
        first_rv = k; got_rd = resp_rdata; got_err = resp_error;
      end
      if (k == last) begin
        chk("pulse_end", 32'(resp_valid), 32'd0);
        chk("ready_back", 32'(req_ready), 32'd1);
        hold_rd = resp_rdata;
      end
      if (k >= s && k < s + nsync)
        lpc_ad_in = (k - s < v.ncodes) ? v.codes[k - s] : 4'hF;
      else if (!abort && !v.wr && k == s + nsync) lpc_ad_in = v.rdata[3:0];
      else if (!abort && !v.wr && k == s + nsync + 1) lpc_ad_in = v.rdata[7:4];
      else lpc_ad_in = 4'hF;
      if (k < last) begin @(posedge clk); #1; end
    end
    lpc_ad_in = 4'hF;
    chk("bus_seq", 32'(bus_bad), 32'd0);
    chk("oe_released", 32'(oe_bad), 32'd0);
    chk("ready_busy", 32'(ready_bad), 32'd0);
    chk("latency", 32'(first_rv), 32'(resp));
    chk("rdata", 32'(got_rd), 32'(m_rd));
    chk("error", 32'(got_err), 32'(m_err));
    chk("rdata_hold", 32'(hold_rd), 32'(m_rd));
  endtask

  vec_t tab[7];
  vec_t rv;
  int   nw, rv_count, resp_seen;

  initial begin
    tab[0] = mkv(0, 0, 32'h0000_7fe5, 8'h00, 8'h6c, 13, 8'h6c, 0);
    tab[0].codes[0] = 4'h0; tab[0].ncodes = 1;
    tab[1] = mkv(0, 1, 32'h0000_0080, 8'ha5, 8'h00, 13, 8'h00, 0);
    tab[1].codes[0] = 4'h0; tab[1].ncodes = 1;
    tab[2] = mkv(1, 0, 32'hffff_fff0, 8'h00, 8'h3c, 19, 8'h3c, 0);
    tab[2].codes[0] = 4'h5; tab[2].codes[1] = 4'h5; tab[2].codes[2] = 4'h0; tab[2].ncodes = 3;
    tab[3] = mkv(0, 0, 32'h0000_1234, 8'h00, 8'h77, 20, 8'h00, 1);
    tab[4] = mkv(0, 0, 32'h0000_0060, 8'h00, 8'h12, 13, 8'h12, 1);
    tab[4].codes[0] = 4'hA; tab[4].ncodes = 1;
    tab[5] = mkv(0, 0, 32'h0000_0cf8, 8'h00, 8'h99, 33, 8'h99, 0);
    for (int i = 0; i < 20; i++) tab[5].codes[i] = 4'h6;
    tab[5].codes[20] = 4'h0; tab[5].ncodes = 21;
    tab[6] = mkv(1, 1, 32'h000c_0010, 8'h5e, 8'h00, 17, 8'h00, 0);
    tab[6].codes[0] = 4'h0; tab[6].ncodes = 1;

    // Reset state while reset is held
    #1 rst_n = 1'b0;
    #2;
    chk("rst_frame", 32'(lpc_frame), 32'd1);
    chk("rst_oe", 32'(lpc_ad_oe), 32'd0);
    chk("rst_ad", 32'(lpc_ad_out), 32'hF);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_rv", 32'(resp_valid), 32'd0);
    chk("rst_rdata", 32'(resp_rdata), 32'h00);
    chk("rst_err", 32'(resp_error), 32'd0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) run_txn(tab[i], 1'b1);

    // Reset asserted in the middle of the address phase
    req_valid = 1'b1; req_mem = 1'b1; req_write = 1'b0; req_addr = 32'hdead_beef;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("mid_in_addr_oe", 32'(lpc_ad_oe), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_frame", 32'(lpc_frame), 32'd1);
    chk("mid_rst_oe", 32'(lpc_ad_oe), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd1);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    resp_seen = 0;
    repeat (30) begin @(posedge clk); #1; if (resp_valid) resp_seen++; end
    chk("mid_rst_no_resp", 32'(resp_seen), 32'd0);
    run_txn(tab[0], 1'b1);

    // Randomized transactions against the model
    rv_count = 40;
    for (int t = 0; t < rv_count; t++) begin
      rv = mkv(1'($urandom), 1'($urandom), $urandom, 8'($urandom), 8'($urandom), 0, 8'h00, 0);
      if ($urandom_range(0, 7) != 0) begin
        nw = $urandom_range(0, 4);
        for (int i = 0; i < nw; i++) begin
          case ($urandom_range(0, 3))
            0: rv.codes[i] = 4'h5;
            1: rv.codes[i] = 4'h6;
            2: rv.codes[i] = 4'hF;
            default: begin
              rv.codes[i] = 4'($urandom_range(0, 15));
              if (rv.codes[i] == 4'h0 || rv.codes[i] == 4'hA) rv.codes[i] = 4'hF;
            end
          endcase
        end
        rv.codes[nw] = ($urandom_range(0, 3) == 0) ? 4'hA : 4'h0;
        rv.ncodes = nw + 1;
      end
      run_txn(rv, 1'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/lpc_host.md
LPC_HOST -- requirements
Module: lpc_host

Interface
REQ-001 The block SHALL have parameter: SYNC_TIMEOUT, 8, SYNC samples without progress before abort (range 1..255).
REQ-002 The block SHALL have port: lpc_clock  in  1  single clock; all state changes and lpc_ad_in sampling on rising edge.
REQ-003 The block SHALL have port: lpc_reset  in  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port: req_valid  in  1  host request present.
REQ-005 The block SHALL have port: req_ready  out  1  request accepted on the edge where req_valid && req_ready.
REQ-006 The block SHALL have port: req_mem  in  1  0 = I/O cycle (16-bit address), 1 = memory cycle (32-bit address).
REQ-007 The block SHALL have port: req_write  in  1  0 = read, 1 = write.
REQ-008 The block SHALL have port: req_addr  in  32  address; I/O cycles use bits 15:0.
REQ-009 The block SHALL have port: req_wdata  in  8  write data.
REQ-010 The block SHALL have ports: resp_valid  out  1  one-cycle completion pulse; resp_rdata  out  8  read data; resp_error  out  1  error or abort.
REQ-011 The block SHALL have ports: lpc_frame  out  1  LFRAME#; lpc_ad_out  out  4; lpc_ad_oe  out  1  drive enable; lpc_ad_in  in  4  sampled bus.

Function
REQ-012 Request fields SHALL be captured at acceptance; later changes SHALL be ignored until the next acceptance.
REQ-013 States SHALL be IDLE, START, CYCTYPE, ADDR, WDATA, TAR1, TAR2, SYNC, RDATA, PTAR, ABORT, RESP; all outputs SHALL be registered.
REQ-014 req_ready SHALL be 1 only in IDLE.
REQ-015 IDLE SHALL drive lpc_frame=1, lpc_ad_oe=0, lpc_ad_out=1111.
REQ-016 START, one cycle: lpc_frame=0, oe=1, ad=0000.
REQ-017 CYCTYPE, one cycle: frame=1, oe=1, ad = {0, req_mem, req_write, 0}.
REQ-018 ADDR: 4 nibbles (I/O) or 8 nibbles (mem), most significant nibble first.
REQ-019 WDATA (writes only): 2 cycles, low nibble first.
REQ-020 TAR1: oe=1, ad=1111; TAR2: oe=0.
REQ-021 SYNC: oe=0; sample lpc_ad_in each edge and act on the code as follows.
- 0000 = ready.
- 1010 = ready with error; resp_error SHALL be set.
- 0101 = short wait; SHALL increment the wait counter.
- 0110 = long wait; SHALL hold the wait counter.
- Any other code SHALL be treated as 1111 (no response) and SHALL increment the wait counter.
REQ-022 The wait counter SHALL clear on entry to SYNC; reaching SYNC_TIMEOUT SHALL enter ABORT.
REQ-023 After ready or error: reads SHALL enter RDATA, sampling low then high nibble on 2 edges; writes SHALL go directly to PTAR.
REQ-024 PTAR: 2 cycles, oe=0, frame=1.
REQ-025 ABORT: 4 cycles, frame=0, oe=1, ad=1111; then RESP with resp_error=1 and resp_rdata=00.
REQ-026 RESP: one cycle; resp_valid=1, frame=1, oe=0; then IDLE.
- resp_rdata SHALL be valid only when resp_valid=1; for writes it SHALL be 00.
- resp_error and resp_rdata SHALL hold until the next RESP.
REQ-027 Latency with zero wait states: resp_valid SHALL be high in the cycle after the 13th edge following acceptance for I/O (read or write) and after the 17th for memory.
- Each wait-sync sample SHALL add exactly one cycle.
REQ-028 lpc_ad_oe SHALL never be 1 during TAR2, SYNC, RDATA or PTAR.

Reset
REQ-029 While lpc_reset=0, asynchronously, the outputs SHALL be: state=IDLE, lpc_frame=1, lpc_ad_oe=0, lpc_ad_out=1111, req_ready=1, resp_valid=0, resp_rdata=00, resp_error=0, wait counter=0.
REQ-030 Reset mid-cycle SHALL abandon the transfer without a resp_valid pulse; the first request after release SHALL start normally.

Verification
REQ-031 The bench SHALL cover: I/O read, addr 0x7fe5; model answers sync 0000, data 0x6c -> ad sequence 0000,0000,7,f,e,5,f,Z,..; resp_valid after edge 13; rdata=6c, error=0.
REQ-032 The bench SHALL cover: I/O write, addr 0x0080, data 0xa5 -> ad 0000,0010,0,0,8,0,5,a,f; sync 0000; resp_valid after edge 13, error=0.
REQ-033 The bench SHALL cover: memory read, addr 0xffff_fff0; model gives 0101,0101,0000, data 0x3c -> resp_valid after edge 19, rdata=3c.
REQ-034 The bench SHALL cover: I/O read with no peripheral (ad_in=1111), SYNC_TIMEOUT=8 -> 8 SYNC cycles, 4 abort cycles (frame=0, ad=1111), resp_error=1, rdata=00.
REQ-035 The bench SHALL cover: sync 1010 on a read, data 0x12 -> rdata=12, error=1.
- 0110 held for 20 cycles SHALL cause no abort.
REQ-036 The bench SHALL cover: reset asserted during ADDR -> frame=1, oe=0 immediately; no resp_valid; next request completes correctly.
